// File: rtl/shake_pad_feeder.sv
// SHAKE pad feeder: message words in, padded words out to the rate-block SIPO; 1-cycle latency per word.
// Backpressure: in_ready drops while a block is pending or pad words are being generated, until block_ack.
module shake_pad_feeder #(
    parameter int WIDTH      = 64,
    parameter int RATE_WORDS = 21
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    input  logic                        in_last,
    input  logic [$clog2(WIDTH/8):0]    in_bytes,
    output logic                        sipo_en,
    output logic [WIDTH-1:0]            sipo_data,
    output logic                        block_valid,
    output logic                        block_last,
    input  logic                        block_ack
);

    localparam int BYTES = WIDTH / 8;
    localparam int BW    = $clog2(BYTES) + 1;
    localparam int CW    = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;

    typedef enum logic [1:0] {
        ABSORB,
        PAD,
        WAIT
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            pad_pending, pad_pending_n;
    logic            block_last_n;
    logic            emit;
    logic [WIDTH-1:0] word_n;
    logic [WIDTH-1:0] absorb_word;
    logic [WIDTH-1:0] pad_word;
    logic            blk_end;
    logic            partial;
    logic            ack_fire;

    assign blk_end  = (cnt == CW'(RATE_WORDS - 1));
    assign partial  = (in_bytes < BW'(BYTES));
    assign ack_fire = (state == WAIT) && block_valid && block_ack;
    assign in_ready = (state == ABSORB);

    // Padded versions of the incoming word and of a generated pad word.
    always_comb begin
        absorb_word = in_data;
        if (in_last && partial) begin
            for (int k = 0; k < BYTES; k++) begin
                if (BW'(k) == in_bytes) begin
                    absorb_word[8*k +: 8] = 8'h1F;
                end else if (BW'(k) > in_bytes) begin
                    absorb_word[8*k +: 8] = 8'h00;
                end
            end
            if (blk_end) begin
                absorb_word[WIDTH-1 -: 8] = absorb_word[WIDTH-1 -: 8] | 8'h80;
            end
        end
        pad_word = '0;
        if (pad_pending) begin
            pad_word[7:0] = 8'h1F;
        end
        if (blk_end) begin
            pad_word[WIDTH-1 -: 8] = pad_word[WIDTH-1 -: 8] | 8'h80;
        end
    end

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        pad_pending_n = pad_pending;
        block_last_n  = block_last;
        emit          = 1'b0;
        word_n        = sipo_data;
        case (state)
            ABSORB: begin
                if (in_valid) begin
                    emit   = 1'b1;
                    word_n = absorb_word;
                    cnt_n  = blk_end ? '0 : cnt + CW'(1);
                    if (blk_end) begin
                        state_n       = WAIT;
                        block_last_n  = in_last && partial;
                        pad_pending_n = in_last && !partial;
                    end else if (in_last) begin
                        state_n       = PAD;
                        pad_pending_n = !partial;
                    end
                end
            end
            PAD: begin
                emit          = 1'b1;
                word_n        = pad_word;
                pad_pending_n = 1'b0;
                cnt_n         = blk_end ? '0 : cnt + CW'(1);
                if (blk_end) begin
                    state_n      = WAIT;
                    block_last_n = 1'b1;
                end
            end
            WAIT: begin
                if (ack_fire) begin
                    state_n      = pad_pending ? PAD : ABSORB;
                    block_last_n = 1'b0;
                end
            end
            default: begin
                state_n = ABSORB;
            end
        endcase
    end

    // block_valid rises one cycle after entering WAIT, once the SIPO has taken the final word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ABSORB;
            cnt         <= '0;
            pad_pending <= 1'b0;
            sipo_en     <= 1'b0;
            sipo_data   <= '0;
            block_valid <= 1'b0;
            block_last  <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            pad_pending <= pad_pending_n;
            sipo_en     <= emit;
            if (emit) begin
                sipo_data <= word_n;
            end
            block_valid <= (state == WAIT) && (state_n == WAIT);
            block_last  <= block_last_n;
        end
    end

endmodule

// File: tb/tb_shake_pad_feeder.sv
// Scoreboard bench for shake_pad_feeder: directed messages, expected padded blocks queued, monitor compares.
module tb_shake_pad_feeder;

    localparam int WIDTH = 64;
    localparam int RW    = 21;
    localparam logic [63:0] TOP80 = 64'h8000_0000_0000_0000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              in_last;
    logic [3:0]        in_bytes;
    logic              sipo_en;
    logic [WIDTH-1:0]  sipo_data;
    logic              block_valid;
    logic              block_last;
    logic              block_ack;

    int checks = 0;
    int fails  = 0;
    int ack_delay = 0;
    logic [63:0] exp_words[$];
    bit          exp_last[$];

    shake_pad_feeder #(.WIDTH(WIDTH), .RATE_WORDS(RW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_bytes    (in_bytes),
        .sipo_en     (sipo_en),
        .sipo_data   (sipo_data),
        .block_valid (block_valid),
        .block_last  (block_last),
        .block_ack   (block_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [63:0] w);
        exp_words.push_back(w);
    endtask

    // Block of the form: w0, nineteen zero words, w20.
    task automatic push_pad_block(input logic [63:0] w0, input logic [63:0] w20, input bit last);
        push_word(w0);
        for (int i = 1; i < RW - 1; i++) push_word(64'd0);
        push_word(w20);
        exp_last.push_back(last);
    endtask

    task automatic send(input logic [63:0] d, input logic l, input logic [3:0] b);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        in_bytes = b;
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("send_handshake_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (exp_last.size() != 0 && t < 600) begin
            @(negedge clk);
            t++;
        end
        check({name, "_drained"}, 64'(exp_last.size()), 64'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_idle(input string name);
        check({name, "_sipo_en"},     64'(sipo_en),     64'd0);
        check({name, "_sipo_data"},   sipo_data,        64'd0);
        check({name, "_block_valid"}, 64'(block_valid), 64'd0);
        check({name, "_block_last"},  64'(block_last),  64'd0);
        check({name, "_in_ready"},    64'(in_ready),    64'd1);
    endtask

    // Monitor: models the SIPO and compares each completed block against the scoreboard.
    initial begin
        logic [63:0] sipo_q[$];
        logic [63:0] e;
        logic [63:0] a;
        bit prev_bv;
        bit prev_en;
        prev_bv = 1'b0;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sipo_q.delete();
                prev_bv = 1'b0;
                prev_en = 1'b0;
            end else begin
                check("sipo_en_while_block_valid", 64'(sipo_en & block_valid), 64'd0);
                if (sipo_en) sipo_q.push_back(sipo_data);
                if (block_valid && !prev_bv) begin
                    check("block_valid_after_last_word", 64'(prev_en), 64'd1);
                    check("block_word_count", 64'(sipo_q.size()), 64'(RW));
                    if (exp_last.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_block: got block, expected none");
                    end else begin
                        for (int i = 0; i < RW; i++) begin
                            e = exp_words.pop_front();
                            a = (i < sipo_q.size()) ? sipo_q[i] : 64'hx;
                            check($sformatf("block_word%0d", i), a, e);
                        end
                        check("block_last", 64'(block_last), 64'(exp_last.pop_front()));
                    end
                    sipo_q.delete();
                end
                prev_bv = block_valid;
                prev_en = sipo_en;
            end
        end
    end

    // Permutation-controller model: acks each block after ack_delay cycles.
    initial begin
        block_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && block_valid) begin
                for (int i = 0; i < ack_delay; i++) begin
                    check("hold_block_valid", 64'(block_valid), 64'd1);
                    check("hold_in_ready",    64'(in_ready),    64'd0);
                    check("hold_sipo_en",     64'(sipo_en),     64'd0);
                    @(negedge clk);
                end
                block_ack = 1'b1;
                @(negedge clk);
                block_ack = 1'b0;
                check("block_valid_after_ack", 64'(block_valid), 64'd0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        in_bytes = '0;
        rst      = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset");

        // Empty message.
        push_pad_block(64'h0000_0000_0000_001F, TOP80, 1'b1);
        send(64'h0, 1'b1, 4'd0);
        wait_drain("empty");

        // 3-byte message; bytes above in_bytes must be discarded.
        push_pad_block(64'h0000_0000_1FCC_BBAA, TOP80, 1'b1);
        send(64'h1234_5678_00CC_BBAA, 1'b1, 4'd3);
        wait_drain("three_byte");

        // 21 full words, last full: data block then an extra pad block.
        for (int i = 0; i < RW; i++) push_word(64'hF000_0000_0000_0000 | 64'(i));
        exp_last.push_back(1'b0);
        push_pad_block(64'h0000_0000_0000_001F, TOP80, 1'b1);
        for (int i = 0; i < RW; i++) send(64'hF000_0000_0000_0000 | 64'(i), (i == RW - 1), 4'd8);
        wait_drain("full_block_full_last");

        // 20 full words + 7-byte last word: 0x1F and 0x80 share the top byte.
        for (int i = 0; i < RW - 1; i++) push_word(64'h0123_4567_89AB_CDEF ^ 64'(i));
        push_word(64'h9FFF_FFFF_FFFF_FFFF);
        exp_last.push_back(1'b1);
        for (int i = 0; i < RW - 1; i++) send(64'h0123_4567_89AB_CDEF ^ 64'(i), 1'b0, 4'd8);
        send(64'hABFF_FFFF_FFFF_FFFF, 1'b1, 4'd7);
        wait_drain("seven_byte_last");

        // 20 full words, last full: pad word carries 0x1F and 0x80 together.
        for (int i = 0; i < RW - 1; i++) push_word(64'h5555_0000_0000_0000 | 64'(i));
        push_word(64'h8000_0000_0000_001F);
        exp_last.push_back(1'b1);
        for (int i = 0; i < RW - 1; i++) send(64'h5555_0000_0000_0000 | 64'(i), (i == RW - 2), 4'd8);
        wait_drain("pad_word_1f_80");

        // One full last word: 0x1F lands in the following word.
        push_word(64'h1122_3344_5566_7788);
        push_word(64'h0000_0000_0000_001F);
        for (int i = 2; i < RW - 1; i++) push_word(64'd0);
        push_word(TOP80);
        exp_last.push_back(1'b1);
        send(64'h1122_3344_5566_7788, 1'b1, 4'd8);
        wait_drain("single_full_word");

        // Backpressure: ack held off 5 cycles while the next word is offered.
        ack_delay = 5;
        for (int i = 0; i < RW; i++) push_word(64'hA5A5_0000_0000_0000 | 64'(i));
        exp_last.push_back(1'b0);
        push_pad_block(64'h0000_0000_001F_7766, TOP80, 1'b1);
        for (int i = 0; i < RW; i++) send(64'hA5A5_0000_0000_0000 | 64'(i), 1'b0, 4'd8);
        send(64'hEEEE_EEEE_EEEE_7766, 1'b1, 4'd2);
        wait_drain("backpressure");
        ack_delay = 0;

        // Reset after 7 words of a message, then a clean message.
        for (int i = 0; i < 7; i++) send(64'h7777_0000_0000_0000 | 64'(i), 1'b0, 4'd8);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("mid_reset");
        push_pad_block(64'h0000_0000_1FCC_BBAA, TOP80, 1'b1);
        send(64'h0000_0000_00CC_BBAA, 1'b1, 4'd3);
        wait_drain("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
